// File: rtl/factorial_iter_engine.sv
// Iterative n! engine: one multiply per cycle, valid/ready on both sides.
// FACTORIAL_ITER_SAT_EN: saturate the result to all-ones on overflow.
module factorial_iter_engine #(
    parameter int N_W = 8,
    parameter int R_W = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N_W-1:0] n,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [R_W-1:0] factorial,
    output logic           ovf,
    output logic           busy
);

    localparam int PW = R_W + N_W;
    localparam logic [N_W-1:0] ONE_N = N_W'(1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic [R_W-1:0] acc;
    logic [R_W-1:0] acc_nxt;
    logic [N_W-1:0] cnt;
    logic [N_W-1:0] cnt_nxt;
    logic           ovf_r;
    logic           ovf_nxt;
    logic [PW-1:0]  prod;
    logic           step_ovf;

    // Full-width product so the lost upper bits can flag overflow.
    assign prod     = PW'(acc) * PW'(cnt);
    assign step_ovf = |prod[PW-1:R_W];

    always_comb begin
        state_nxt = state;
        acc_nxt   = acc;
        cnt_nxt   = cnt;
        ovf_nxt   = ovf_r;
        unique case (state)
            IDLE: begin
                if (in_valid) begin
                    acc_nxt   = R_W'(1);
                    cnt_nxt   = n;
                    ovf_nxt   = 1'b0;
                    state_nxt = CALC;
                end
            end
            CALC: begin
                if (cnt > ONE_N) begin
                    cnt_nxt = cnt - ONE_N;
                    ovf_nxt = ovf_r | step_ovf;
`ifdef FACTORIAL_ITER_SAT_EN
                    acc_nxt = (ovf_r | step_ovf) ? '1 : prod[R_W-1:0];
`else
                    acc_nxt = prod[R_W-1:0];
`endif
                end else begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            acc   <= R_W'(1);
            cnt   <= '0;
            ovf_r <= 1'b0;
        end else begin
            state <= state_nxt;
            acc   <= acc_nxt;
            cnt   <= cnt_nxt;
            ovf_r <= ovf_nxt;
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign factorial = acc;
    assign ovf       = ovf_r;

endmodule

// File: doc/factorial_iter_engine.md
FACTORIAL_ITER_ENGINE -- requirements
Module: factorial_iter_engine

Interface
REQ-001 SHALL have parameter N_W, default 8: operand width in bits; legal range 2..16.
REQ-002 SHALL have parameter R_W, default 16: result width in bits; legal range N_W..64.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous to clk, active-high.
REQ-005 SHALL have port in_valid, input, 1 bit: operand offered.
REQ-006 SHALL have port in_ready, output, 1 bit: engine can accept an operand.
REQ-007 SHALL have port n, input, N_W bits: unsigned operand, sampled on accept.
REQ-008 SHALL have port out_valid, output, 1 bit: result available.
REQ-009 SHALL have port out_ready, input, 1 bit: consumer takes the result.
REQ-010 SHALL have port factorial, output, R_W bits: unsigned result.
REQ-011 SHALL have port ovf, output, 1 bit: the true n! did not fit in R_W bits.
REQ-012 SHALL have port busy, output, 1 bit: high in any state other than IDLE.

Function
REQ-013 SHALL implement a three-state FSM:
- IDLE: accepts an operand.
- CALC: iterates the product.
- DONE: holds the result.
REQ-014 SHALL drive in_ready high only in IDLE; accept occurs on a clk edge with in_valid and in_ready both high.
REQ-015 On accept SHALL load acc=1, cnt=n and ovf_r=0, then enter CALC.
REQ-016 In CALC with cnt>1, each edge SHALL:
- set acc to the low R_W bits of acc*cnt, using an R_W+N_W-bit product;
- decrement cnt by 1.
REQ-017 In CALC with cnt<=1, the edge SHALL enter DONE with no multiply.
REQ-018 Latency SHALL be exact: out_valid rises max(n,1) cycles after the accept edge, so n=0 and n=1 take 1 cycle and n=5 takes 5 cycles.
REQ-019 SHALL drive out_valid high only in DONE; factorial and ovf SHALL stay stable while out_valid is high.
REQ-020 In DONE, out_valid and out_ready both high SHALL return the FSM to IDLE on that edge; in_ready rises the following cycle, so start and finish never overlap.
REQ-021 SHALL hold DONE indefinitely while out_ready is low (backpressure).
REQ-022 ovf_r SHALL set when any step's upper N_W product bits are nonzero, and SHALL stay set until the next accept.
REQ-023 in_valid SHALL be ignored outside IDLE; n SHALL be sampled only on the accept edge.
REQ-024 With default parameters, n<=8 SHALL never assert ovf (8!=40320), and n>=9 SHALL always assert ovf.

Reset
REQ-025 With rst high on an edge, the engine SHALL apply:
- state=IDLE, acc=1, cnt=0, ovf_r=0;
- out_valid=0, busy=0, ovf=0, factorial=1;
- in_ready=1 from the first cycle after reset.
REQ-026 rst SHALL take priority over every other event, including a simultaneous accept or output handshake.
REQ-027 rst in CALC or DONE SHALL discard the operation; out_valid SHALL not assert for it.

Configuration
REQ-028 Macro FACTORIAL_ITER_SAT_EN SHALL select the result behaviour on overflow:
- Defined: the first overflowing step forces acc to all-ones and acc stays all-ones for the rest of the operation.
- Undefined: acc wraps modulo 2^R_W, so factorial = n! mod 2^R_W.
REQ-029 The macro SHALL affect neither ovf, latency nor the handshake.

Verification
REQ-030 SHALL check reset:
- Stimulus: rst high 2 cycles, then low.
- Response: in_ready=1, out_valid=0, busy=0, factorial=1, ovf=0.
REQ-031 SHALL check a normal operand:
- Stimulus: n=5 accepted, out_ready=1.
- Response: out_valid rises exactly 5 cycles after accept with factorial=120, ovf=0; n=8 gives 40320.
REQ-032 SHALL check boundary operands:
- Stimulus: n=0, then n=1.
- Response: each gives factorial=1 and ovf=0, 1 cycle after accept.
REQ-033 SHALL check overflow:
- Stimulus: n=9, then n=10.
- Response without macro: 35200 and 24320, ovf=1.
- Response with FACTORIAL_ITER_SAT_EN: 0xFFFF, ovf=1.
- Latency: 9 and 10 cycles in both builds.
REQ-034 SHALL check backpressure:
- Stimulus: n=4, out_ready low 6 cycles, then high.
- Response: factorial=24 held stable; in_ready=0 throughout; in_valid pulses during the hold are ignored.
REQ-035 SHALL check reset mid-operation:
- Stimulus: n=7, rst on the 3rd cycle of CALC, then n=3.
- Response: no out_valid for 7; result 6 after 3 cycles.
